systolic_mm_ctrl: RTL and testbench
===================================

Name: systolic_mm_ctrl

Overview:
Sequencer for an N x N output-stationary systolic array of fp8-in/bf16-accumulate PEs. It does four things:
- snapshots an A (N x K) and B (K x N) fp8 operand tile on start;
- clears the PE accumulators;
- drives skewed operand wavefronts into the array's left and top edges;
- waits out the PE pipeline latency, then captures the N x N bf16 results.

It sits between the host/operand buffers and the PE grid, and is the only driver of the array edges and of the PE clear line.

Parameters:
N, 2, array dimension (rows = cols)
K, 2, inner (reduction) dimension, >= 1
PE_LAT, 3, cycles from a PE input to the accumulator update visible on c_out

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a matmul; sampled only in IDLE
a_mat  in  N*K*8  fp8 A tile; element A[i][k] at bits [(i*K+k)*8 +: 8]
b_mat  in  K*N*8  fp8 B tile; element B[k][j] at bits [(k*N+j)*8 +: 8]
c_flat  in  N*N*16  bf16 PE accumulators; PE(i,j) at bits [(i*N+j)*16 +: 16]
a_edge  out  N*8  fp8 into the left column; row i at bits [i*8 +: 8]
b_edge  out  N*8  fp8 into the top row; col j at bits [j*8 +: 8]
pe_clear  out  1  synchronous accumulator clear to all PEs
busy  out  1  high from CLEAR through DONE
done  out  1  one-cycle pulse; result is valid
result  out  N*N*16  captured C tile, same layout as c_flat
result_valid  out  1  high from done until the next accepted start

Behaviour:
- Reset (async, rst_n=0), all outputs 0:
  - state=IDLE; a_edge, b_edge = 8'h00 (fp8 +0); pe_clear, busy, done, result_valid = 0; result = 0; snapshot registers = 0.
- All outputs are registered.
- Derived constant: F = K + 2(N-1) feed cycles.
- FSM states: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - Edges are held at 0.
  - On start=1: capture a_mat and b_mat into snapshots, clear result_valid, go to CLEAR.
- CLEAR (1 cycle):
  - pe_clear=1, edges 0.
  - Next state FEED, with feed counter t=0.
- FEED (F cycles, t = 0..F-1):
  - a_edge row i = A[i][t-i] when 0 <= t-i < K, else 8'h00.
  - b_edge col j = B[t-j][j] when 0 <= t-j < K, else 8'h00.
  - Counter width is clog2(F+1). At t=F-1, go to DRAIN.
- DRAIN (PE_LAT cycles, own counter):
  - Edges are 0.
  - After the last drain cycle, go to DONE.
- DONE (1 cycle):
  - result <= c_flat at the end of the cycle; next state IDLE.
  - In the following cycle: done=1 for exactly one cycle and result_valid=1.
- busy=1 in the CLEAR, FEED, DRAIN and DONE states.
- Latency: with start sampled high in cycle 0, done is high in cycle F+PE_LAT+3. For N=2, K=2, PE_LAT=3 that is cycle 10.
- start while not in IDLE is ignored: no queueing, and the snapshot is unchanged.
- start in the same cycle done is high is accepted (the FSM is already in IDLE). result_valid falls in the next cycle.
- Operand changes on a_mat/b_mat after the accepting cycle have no effect.
- Zero fill:
  - Out-of-window slots are fp8 +0, so they add bf16 +0 to the accumulators.
  - DRAIN zeros flush the PE pipeline, so no stale product crosses the next CLEAR.
- Reset mid-operation returns to IDLE immediately:
  - edges 0, pe_clear 0, result cleared, result_valid 0;
  - no done pulse.

Decomposition:
- Shared package tpu_ctrl_pkg:
  - FSM state enum (IDLE, CLEAR, FEED, DRAIN, DONE);
  - FP8_ZERO = 8'h00, BF16_ZERO = 16'h0000;
  - localparam helpers for F and the counter widths.
- One sub-module, systolic_skew_feeder:
  - Combinational element select plus the edge output registers.
  - Inputs: snapshot tile, t, feed_en. Output: a_edge/b_edge.
  - Instantiated once, driving both edges.
- The FSM, counters and result capture live in the top.

Test Plan:
1. Skew check: N=2, K=2, A = {A00=0x38, A01=0x40, A10=0x48, A11=0x50}, B likewise; start.
   -> pe_clear high only in cycle 1.
   -> a_edge per FEED cycle t=0..3: row0 = 38,40,00,00 and row1 = 00,48,50,00. b_edge mirrors this by column.
2. Full matmul with the PE grid attached: A all 0x38 (1.0), B all 0x38.
   -> done in cycle 10; all four result words 0x4000 (2.0); result_valid=1.
3. Identity: A = diag 0x38 (off-diagonal 00), B = {0x40, 0x38, 0x38, 0x40}.
   -> result = {0x4000, 0x3F80, 0x3F80, 0x4000}.
4. start pulsed in cycles 3 and 6 (busy), with a_mat changed meanwhile.
   -> ignored; exactly one done, and the result matches the original snapshot.
5. rst_n low in FEED cycle t=2 and released.
   -> all outputs 0 asynchronously, state IDLE, no done.
   -> A new start then completes correctly with no residue from the aborted run.
6. Back-to-back: start held high through the done cycle.
   -> second run accepted; result_valid drops the next cycle.
   -> second done comes F+PE_LAT+3 cycles after the accepting cycle, with the correct new result.

Source files
------------

// File: rtl/systolic_mm_ctrl_pkg.sv
// Shared types and constants for the systolic matmul sequencer.
// Holds FSM state codes, fp8/bf16 zero encodings and the feed/counter sizing helpers.
package tpu_ctrl_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_CLEAR = 3'd1;
   localparam state_t ST_FEED  = 3'd2;
   localparam state_t ST_DRAIN = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

   localparam logic [7:0]  FP8_ZERO  = 8'h00;
   localparam logic [15:0] BF16_ZERO = 16'h0000;

   // Length of the skewed wavefront: the last row/column starts N-1 cycles late
   // and the last element crosses N-1 more PEs.
   function automatic int feed_cycles(input int n, input int k);
      return k + 2 * (n - 1);
   endfunction

   function automatic int cnt_width(input int max_val);
      return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/systolic_mm_ctrl_if.sv
// Host/array-side bundle of the systolic sequencer.
// The sequencer takes the slave view; the host, operand buffers and PE grid take the master view.
interface systolic_mm_ctrl_if #(
   parameter int N = 2,
   parameter int K = 2
);
   logic                start;
   logic [N*K*8-1:0]    a_mat;
   logic [K*N*8-1:0]    b_mat;
   logic [N*N*16-1:0]   c_flat;
   logic [N*8-1:0]      a_edge;
   logic [N*8-1:0]      b_edge;
   logic                pe_clear;
   logic                busy;
   logic                done;
   logic [N*N*16-1:0]   result;
   logic                result_valid;

   modport master (
      output start, a_mat, b_mat, c_flat,
      input  a_edge, b_edge, pe_clear, busy, done, result, result_valid
   );

   modport slave (
      input  start, a_mat, b_mat, c_flat,
      output a_edge, b_edge, pe_clear, busy, done, result, result_valid
   );
endinterface

// File: rtl/systolic_mm_ctrl_skew_feeder.sv
// Skewed operand selector for the array edges: row i lags by i cycles, column j by j cycles.
// Element select is combinational on the upcoming feed index; the edges themselves are registered.
module systolic_skew_feeder
   import tpu_ctrl_pkg::*;
#(
   parameter int N  = 2,
   parameter int K  = 2,
   parameter int TW = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N*K*8-1:0]    a_snap_i,
   input  logic [K*N*8-1:0]    b_snap_i,
   input  logic [TW-1:0]       t_i,
   input  logic                feed_en_i,
   output logic [N*8-1:0]      a_edge_o,
   output logic [N*8-1:0]      b_edge_o
);

   logic [N*8-1:0] a_edge_d, a_edge_q;
   logic [N*8-1:0] b_edge_d, b_edge_q;

   always_comb begin
      int ka;
      int kb;
      // NOTE: every output of this block is given a value before any branch, so no latch is inferred.
      a_edge_d = {N{FP8_ZERO}};
      b_edge_d = {N{FP8_ZERO}};
      ka       = 0;
      kb       = 0;
      for (int i = 0; i < N; i++) begin
         ka = int'(t_i) - i;
         if (feed_en_i && ka >= 0 && ka < K)
            a_edge_d[i*8 +: 8] = a_snap_i[(i*K + ka)*8 +: 8];
      end
      for (int j = 0; j < N; j++) begin
         kb = int'(t_i) - j;
         if (feed_en_i && kb >= 0 && kb < K)
            b_edge_d[j*8 +: 8] = b_snap_i[(kb*N + j)*8 +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_edge_q <= {N{FP8_ZERO}};
         b_edge_q <= {N{FP8_ZERO}};
      end else begin
         // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
         a_edge_q <= a_edge_d;
         b_edge_q <= b_edge_d;
      end
   end

   assign a_edge_o = a_edge_q;
   assign b_edge_o = b_edge_q;

endmodule

// File: rtl/systolic_mm_ctrl.sv
// Sequencer for an N x N output-stationary fp8/bf16 systolic array: snapshot operands,
// clear PEs, feed skewed wavefronts, wait out PE latency, capture the C tile.
module systolic_mm_ctrl
   import tpu_ctrl_pkg::*;
#(
   parameter int N      = 2,
   parameter int K      = 2,
   parameter int PE_LAT = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   systolic_mm_ctrl_if.slave     bus
);

   localparam int F  = feed_cycles(N, K);
   localparam int TW = cnt_width(F);
   localparam int DW = cnt_width(PE_LAT);
   localparam logic [TW-1:0] T_LAST = TW'(F - 1);
   localparam logic [DW-1:0] D_LAST = DW'(PE_LAT - 1);

   state_t                state_q, state_d;
   logic [TW-1:0]         t_q, t_d;
   logic [DW-1:0]         d_q, d_d;
   logic [N*K*8-1:0]      a_snap_q;
   logic [K*N*8-1:0]      b_snap_q;
   logic                  pe_clear_q, busy_q, done_q, result_valid_q;
   logic [N*N*16-1:0]     result_q;
   logic [N*8-1:0]        a_edge_w, b_edge_w;
   logic                  accept;

   assign accept = (state_q == ST_IDLE) && bus.start;

   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      d_d     = d_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_CLEAR;
         ST_CLEAR: begin
            state_d = ST_FEED;
            t_d     = '0;
         end
         ST_FEED: begin
            if (t_q == T_LAST) begin
               state_d = ST_DRAIN;
               d_d     = '0;
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         ST_DRAIN: begin
            if (d_q == D_LAST) state_d = ST_DONE;
            else               d_d     = d_q + DW'(1);
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from next-state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         t_q            <= '0;
         d_q            <= '0;
         // NOTE: the operand snapshots and result tile are reset too; they are plain flops, not RAM,
         // and a defined zero after reset keeps an aborted run from leaking into the next one.
         a_snap_q       <= '0;
         b_snap_q       <= '0;
         result_q       <= {N*N{BF16_ZERO}};
         pe_clear_q     <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         t_q        <= t_d;
         d_q        <= d_d;
         pe_clear_q <= (state_d == ST_CLEAR);
         busy_q     <= (state_d != ST_IDLE);
         done_q     <= (state_q == ST_DONE);
         if (accept) begin
            a_snap_q <= bus.a_mat;
            b_snap_q <= bus.b_mat;
         end
         if (state_q == ST_DONE) begin
            result_q       <= bus.c_flat;
            result_valid_q <= 1'b1;
         end else if (accept) begin
            result_valid_q <= 1'b0;
         end
      end
   end

   systolic_skew_feeder #(
      .N  (N),
      .K  (K),
      .TW (TW)
   ) u_feeder (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_snap_i  (a_snap_q),
      .b_snap_i  (b_snap_q),
      .t_i       (t_d),
      .feed_en_i (state_d == ST_FEED),
      .a_edge_o  (a_edge_w),
      .b_edge_o  (b_edge_w)
   );

   assign bus.a_edge       = a_edge_w;
   assign bus.b_edge       = b_edge_w;
   assign bus.pe_clear     = pe_clear_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;

endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// Bench for systolic_mm_ctrl: behavioural PE grid on c_flat, a cycle-timeline model of the
// sequencer checked every cycle, and directed runs with hand-computed literal expectations.
module tb_systolic_mm_ctrl;

   localparam int N        = 2;
   localparam int K        = 2;
   localparam int PE_LAT   = 3;
   localparam int F        = K + 2 * (N - 1);
   localparam int DONE_REL = F + PE_LAT + 3;
   localparam int HIST     = 4096;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc       = 0;
   int   vectors   = 0;
   int   fails     = 0;
   int   done_seen = 0;

   systolic_mm_ctrl_if #(.N(N), .K(K)) ifc ();

   systolic_mm_ctrl #(.N(N), .K(K), .PE_LAT(PE_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, exp);
      end
   endtask

   function automatic real fp8r(input logic [7:0] b);
      int  e;
      real v;
      e = int'(b[6:3]);
      v = real'(int'(b[2:0])) / 8.0;
      if (e == 0) v = v / 64.0;
      else begin
         v = 1.0 + v;
         for (int x = 7; x < e; x++) v = v * 2.0;
         for (int x = e; x < 7; x++) v = v / 2.0;
      end
      return b[7] ? -v : v;
   endfunction

   function automatic logic [15:0] r2bf(input real x);
      real  m;
      int   e;
      logic s;
      if (x == 0.0) return 16'h0000;
      s = (x < 0.0);
      m = s ? -x : x;
      e = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0)  begin m = m * 2.0; e--; end
      return {s, 8'(e + 127), 7'(int'($floor((m - 1.0) * 128.0)))};
   endfunction

   function automatic logic [N*N*16-1:0] matmul(input logic [N*K*8-1:0] a, input logic [K*N*8-1:0] b);
      logic [N*N*16-1:0] r;
      real s;
      r = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            s = 0.0;
            for (int k = 0; k < K; k++)
               s = s + fp8r(a[(i*K+k)*8 +: 8]) * fp8r(b[(k*N+j)*8 +: 8]);
            r[(i*N+j)*16 +: 16] = r2bf(s);
         end
      return r;
   endfunction

   // PE grid: PE(i,j) sees row i delayed by j and column j delayed by i; product visible PE_LAT later.
   logic [N*8-1:0] ah [HIST];
   logic [N*8-1:0] bh [HIST];
   logic           clrh [HIST];
   real            acc [N][N];

   always @(negedge clk) begin
      int p, pa, pb;
      logic [N*N*16-1:0] cf;
      if (cyc < HIST) begin
         ah[cyc]   = ifc.a_edge;
         bh[cyc]   = ifc.b_edge;
         clrh[cyc] = ifc.pe_clear;
         if (cyc >= 2 && clrh[cyc-1])
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++) acc[i][j] = 0.0;
         p = cyc - PE_LAT;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               pa = p - j;
               pb = p - i;
               if (pa >= 1 && pb >= 1)
                  acc[i][j] = acc[i][j] + fp8r(ah[pa][i*8 +: 8]) * fp8r(bh[pb][j*8 +: 8]);
            end
      end
      cf = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) cf[(i*N+j)*16 +: 16] = r2bf(acc[i][j]);
      ifc.c_flat = cf;
   end

   // Timeline model: everything is a function of the cycles elapsed since the accepted start.
   logic              run_on = 1'b0;
   int                run_s  = 0;
   logic              rv_m   = 1'b0;
   logic [N*N*16-1:0] res_m  = '0;
   logic [N*N*16-1:0] res_pend = '0;
   logic [N*K*8-1:0]  a_s = '0;
   logic [K*N*8-1:0]  b_s = '0;

   always @(negedge clk) begin
      int rel, t;
      logic [N*8-1:0] ea, eb;
      if (!rst_n) begin
         run_on = 1'b0;
         rv_m   = 1'b0;
         res_m  = '0;
      end
      rel = run_on ? (cyc - run_s) : -1;
      if (rel == DONE_REL) begin
         rv_m  = 1'b1;
         res_m = res_pend;
      end
      ea = '0;
      eb = '0;
      t  = rel - 2;
      if (t >= 0 && t < F) begin
         for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < K) ea[i*8 +: 8] = a_s[(i*K + t - i)*8 +: 8];
         for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < K) eb[j*8 +: 8] = b_s[((t - j)*N + j)*8 +: 8];
      end
      check("pe_clear", 64'(ifc.pe_clear), 64'(rel == 1));
      check("busy", 64'(ifc.busy), 64'(rel >= 1 && rel <= DONE_REL - 1));
      check("done", 64'(ifc.done), 64'(rel == DONE_REL));
      check("result_valid", 64'(ifc.result_valid), 64'(rv_m));
      check("a_edge", 64'(ifc.a_edge), 64'(ea));
      check("b_edge", 64'(ifc.b_edge), 64'(eb));
      check("result", 64'(ifc.result), 64'(res_m));
      if (ifc.done === 1'b1) done_seen++;
      if (rst_n && ifc.start && (!run_on || rel >= DONE_REL)) begin
         run_on   = 1'b1;
         run_s    = cyc;
         a_s      = ifc.a_mat;
         b_s      = ifc.b_mat;
         res_pend = matmul(ifc.a_mat, ifc.b_mat);
         rv_m     = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto(input int target);
      while (cyc < target) step();
   endtask

   task automatic at_neg(input int target);
      goto(target);
      @(negedge clk);
   endtask

   task automatic start_run(input logic [31:0] a, input logic [31:0] b, output int s);
      step();
      ifc.a_mat = a;
      ifc.b_mat = b;
      ifc.start = 1'b1;
      s = cyc;
      step();
      ifc.start = 1'b0;
   endtask

   localparam logic [31:0] OPS_SKEW = 32'h5048_4038;
   localparam logic [31:0] OPS_ONE  = 32'h3838_3838;
   localparam logic [31:0] A_IDENT  = 32'h3800_0038;
   localparam logic [31:0] B_IDENT  = 32'h4038_3840;
   localparam logic [63:0] C_TWO    = 64'h4000_4000_4000_4000;
   localparam logic [63:0] C_IDENT  = 64'h4000_3F80_3F80_4000;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, d0;
      ifc.start = 1'b0;
      ifc.a_mat = '0;
      ifc.b_mat = '0;

      // Reset state
      step();
      step();
      check("reset busy", 64'(ifc.busy), 64'd0);
      check("reset result_valid", 64'(ifc.result_valid), 64'd0);
      check("reset edges", 64'({ifc.a_edge, ifc.b_edge}), 64'd0);
      check("reset result", 64'(ifc.result), 64'd0);
      rst_n = 1'b1;

      // 1: skew pattern; 9,18,36,72 in bf16
      start_run(OPS_SKEW, OPS_SKEW, s);
      at_neg(s + 1);
      check("t1 pe_clear c1", 64'(ifc.pe_clear), 64'd1);
      at_neg(s + 2);
      check("t1 pe_clear c2", 64'(ifc.pe_clear), 64'd0);
      check("t1 a t0", 64'(ifc.a_edge), 64'h0038);
      check("t1 b t0", 64'(ifc.b_edge), 64'h0038);
      at_neg(s + 3);
      check("t1 a t1", 64'(ifc.a_edge), 64'h4840);
      check("t1 b t1", 64'(ifc.b_edge), 64'h4048);
      at_neg(s + 4);
      check("t1 a t2", 64'(ifc.a_edge), 64'h5000);
      check("t1 b t2", 64'(ifc.b_edge), 64'h5000);
      at_neg(s + 5);
      check("t1 a t3", 64'(ifc.a_edge), 64'h0000);
      check("t1 b t3", 64'(ifc.b_edge), 64'h0000);
      at_neg(s + 10);
      check("t1 done@10", 64'(ifc.done), 64'd1);
      check("t1 result", 64'(ifc.result), 64'h4290_4210_4190_4110);

      // 2: all ones
      start_run(OPS_ONE, OPS_ONE, s);
      at_neg(s + 9);
      check("t2 no done@9", 64'(ifc.done), 64'd0);
      at_neg(s + 10);
      check("t2 done@10", 64'(ifc.done), 64'd1);
      check("t2 result", 64'(ifc.result), C_TWO);
      check("t2 result_valid", 64'(ifc.result_valid), 64'd1);

      // 3: identity times B
      start_run(A_IDENT, B_IDENT, s);
      at_neg(s + 10);
      check("t3 result", 64'(ifc.result), C_IDENT);

      // 4: start while busy is ignored, operand change after accept has no effect
      start_run(OPS_ONE, OPS_ONE, s);
      d0 = done_seen;
      goto(s + 3);
      ifc.start = 1'b1;
      ifc.a_mat = 32'h4848_4848;
      step();
      ifc.start = 1'b0;
      goto(s + 6);
      ifc.start = 1'b1;
      step();
      ifc.start = 1'b0;
      at_neg(s + DONE_REL + 4);
      check("t4 done count", 64'(done_seen - d0), 64'd1);
      check("t4 result", 64'(ifc.result), C_TWO);

      // 5: reset in FEED t=2, then a clean run
      start_run(OPS_SKEW, OPS_SKEW, s);
      goto(s + 4);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5 async edges", 64'({ifc.a_edge, ifc.b_edge}), 64'd0);
      check("t5 async busy", 64'({ifc.busy, ifc.pe_clear, ifc.done, ifc.result_valid}), 64'd0);
      check("t5 async result", 64'(ifc.result), 64'd0);
      d0 = done_seen;
      step();
      step();
      rst_n = 1'b1;
      at_neg(s + DONE_REL + 4);
      check("t5 no done after abort", 64'(done_seen - d0), 64'd0);
      start_run(A_IDENT, B_IDENT, s);
      at_neg(s + 10);
      check("t5 done@10", 64'(ifc.done), 64'd1);
      check("t5 result", 64'(ifc.result), C_IDENT);

      // 6: start held high through done
      step();
      ifc.a_mat = OPS_ONE;
      ifc.b_mat = OPS_ONE;
      ifc.start = 1'b1;
      s = cyc;
      goto(s + 5);
      ifc.a_mat = A_IDENT;
      ifc.b_mat = B_IDENT;
      at_neg(s + 10);
      check("t6 first done", 64'(ifc.done), 64'd1);
      check("t6 first result", 64'(ifc.result), C_TWO);
      step();
      ifc.start = 1'b0;
      at_neg(s + 11);
      check("t6 rv drop", 64'(ifc.result_valid), 64'd0);
      check("t6 busy again", 64'(ifc.busy), 64'd1);
      at_neg(s + 20);
      check("t6 second done", 64'(ifc.done), 64'd1);
      check("t6 second result", 64'(ifc.result), C_IDENT);
      at_neg(s + 22);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
